// File: rtl/tuner_lock_phy_pkg.sv
// Shared types and helpers for the microring lock stage: FSM state encoding,
// best-of-three choice codes and the saturating probe-offset function.
package tuner_phy_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_PEAKS = 4'd1,
    ERR        = 4'd2,
    APPLY_C    = 4'd3,
    MEAS_C     = 4'd4,
    APPLY_P    = 4'd5,
    MEAS_P     = 4'd6,
    APPLY_M    = 4'd7,
    MEAS_M     = 4'd8,
    UPDATE     = 4'd9
  } tuner_lock_state_e;

  localparam logic [1:0] CH_CENTER = 2'd0;
  localparam logic [1:0] CH_PLUS   = 2'd1;
  localparam logic [1:0] CH_MINUS  = 2'd2;

  // Offset a code by step in either direction, clamping to [0, max_code].
  function automatic logic [31:0] sat_offset(input logic [31:0] code,
                                             input logic [31:0] step,
                                             input logic [31:0] max_code,
                                             input logic        up);
    logic [32:0] sum;
    sum = {1'b0, code} + {1'b0, step};
    if (up) return (sum > {1'b0, max_code}) ? max_code : sum[31:0];
    return (code < step) ? '0 : code - step;
  endfunction

endpackage

// File: rtl/tuner_lock_phy_cmp.sv
// Combinational best-of-three power selector; ties prefer center, then plus.
module tuner_lock_cmp
  import tuner_phy_pkg::*;
#(
  parameter int ADC_WIDTH = 8
) (
  input  logic [ADC_WIDTH-1:0] pc,
  input  logic [ADC_WIDTH-1:0] pp,
  input  logic [ADC_WIDTH-1:0] pm,
  output logic [1:0]           choice
);

  always_comb begin
    choice = CH_CENTER;
    if (pc >= pp && pc >= pm) choice = CH_CENTER;
    else if (pp >= pm)        choice = CH_PLUS;
    else                      choice = CH_MINUS;
  end

endmodule

// File: rtl/tuner_lock_phy.sv
// Microring lock stage: latches a selected peak, then runs a center/plus/minus
// dither hill-climb. Optional TUNER_LOCK_DISCARD_EN drops one stale sample per MEAS.
module tuner_lock_phy
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH   = 8,
  parameter int ADC_WIDTH   = 8,
  parameter int NUM_TARGET  = 4,
  parameter int DITHER_STEP = 1,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_lock_en,
  input  logic [$clog2(NUM_TARGET)-1:0]   i_lock_sel,
  input  logic                            i_peaks_val,
  output logic                            o_peaks_rdy,
  input  logic [NUM_TARGET*DAC_WIDTH-1:0] i_ring_tune_peaks,
  input  logic [NUM_TARGET*ADC_WIDTH-1:0] i_pwr_peaks,
  input  logic [$clog2(NUM_TARGET):0]     i_peaks_cnt,
  output logic                            o_ring_tune_val,
  input  logic                            i_ring_tune_rdy,
  output logic [DAC_WIDTH-1:0]            o_ring_tune,
  input  logic                            i_pwr_val,
  output logic                            o_pwr_rdy,
  input  logic [ADC_WIDTH-1:0]            i_pwr,
  output logic                            o_locked,
  output logic                            o_lock_err,
  output logic [DAC_WIDTH-1:0]            o_mon_center,
  output tuner_lock_state_e               o_mon_state
);

  localparam int SEL_W = $clog2(NUM_TARGET);
  localparam int STB_W = $clog2(LOCK_COUNT + 1);
  localparam logic [31:0] MAX_CODE = 32'((64'd1 << DAC_WIDTH) - 64'd1);
  localparam logic [31:0] STEP     = 32'(DITHER_STEP);
  localparam logic [STB_W-1:0] LOCK_MAX = STB_W'(LOCK_COUNT);

  tuner_lock_state_e    state;
  logic [DAC_WIDTH-1:0] center;
  logic [DAC_WIDTH-1:0] tune;
  logic [DAC_WIDTH-1:0] code_p;
  logic [DAC_WIDTH-1:0] code_m;
  logic [DAC_WIDTH-1:0] code_sel;
  logic [DAC_WIDTH-1:0] code_next;
  logic [ADC_WIDTH-1:0] pc;
  logic [ADC_WIDTH-1:0] pp;
  logic [ADC_WIDTH-1:0] pm;
  logic [STB_W-1:0]     stable;
  logic [STB_W-1:0]     stable_nx;
  logic [1:0]           choice;
  logic                 locked;
  logic                 tune_val;
  logic                 sel_err;
  logic                 tune_hs;
  logic                 pwr_take;
  logic                 meas;
  logic                 unused_pwr_peaks;

  assign unused_pwr_peaks = ^i_pwr_peaks;

  assign code_p    = DAC_WIDTH'(sat_offset(32'(center), STEP, MAX_CODE, 1'b1));
  assign code_m    = DAC_WIDTH'(sat_offset(32'(center), STEP, MAX_CODE, 1'b0));
  assign sel_err   = ({1'b0, i_lock_sel} >= i_peaks_cnt);
  assign tune_hs   = tune_val && i_ring_tune_rdy;
  assign meas      = (state == MEAS_C) || (state == MEAS_P) || (state == MEAS_M);
  assign stable_nx = stable + STB_W'(1);

  always_comb begin
    code_sel = '0;
    for (int unsigned i = 0; i < NUM_TARGET; i++)
      if (i_lock_sel == SEL_W'(i)) code_sel = i_ring_tune_peaks[i*DAC_WIDTH +: DAC_WIDTH];
  end

  tuner_lock_cmp #(.ADC_WIDTH(ADC_WIDTH)) u_cmp (
    .pc     (pc),
    .pp     (pp),
    .pm     (pm),
    .choice (choice)
  );

  always_comb begin
    code_next = center;
    case (choice)
      CH_PLUS:  code_next = code_p;
      CH_MINUS: code_next = code_m;
      default:  code_next = center;
    endcase
  end

`ifdef TUNER_LOCK_DISCARD_EN
  // Toggles on each accepted sample: the first is dropped, the second captured.
  logic skip_done;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    skip_done <= 1'b0;
    else if (!i_lock_en || !meas) skip_done <= 1'b0;
    else if (i_pwr_val)           skip_done <= !skip_done;
  end
  assign pwr_take = i_pwr_val && skip_done;
`else
  assign pwr_take = i_pwr_val;
`endif

  // Tune code and valid are registered alongside the APPLY transition so the
  // request is presented in the first APPLY cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      center   <= '0;
      tune     <= '0;
      tune_val <= 1'b0;
      pc       <= '0;
      pp       <= '0;
      pm       <= '0;
      stable   <= '0;
      locked   <= 1'b0;
    end else if (!i_lock_en) begin
      state    <= IDLE;
      tune_val <= 1'b0;
      stable   <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= WAIT_PEAKS;
        WAIT_PEAKS: begin
          if (i_peaks_val) begin
            if (sel_err) begin
              state <= ERR;
            end else begin
              center   <= code_sel;
              tune     <= code_sel;
              tune_val <= 1'b1;
              stable   <= '0;
              state    <= APPLY_C;
            end
          end
        end
        ERR: state <= ERR;
        APPLY_C: if (tune_hs) begin tune_val <= 1'b0; state <= MEAS_C; end
        APPLY_P: if (tune_hs) begin tune_val <= 1'b0; state <= MEAS_P; end
        APPLY_M: if (tune_hs) begin tune_val <= 1'b0; state <= MEAS_M; end
        MEAS_C: begin
          if (pwr_take) begin
            pc       <= i_pwr;
            tune     <= code_p;
            tune_val <= 1'b1;
            state    <= APPLY_P;
          end
        end
        MEAS_P: begin
          if (pwr_take) begin
            pp       <= i_pwr;
            tune     <= code_m;
            tune_val <= 1'b1;
            state    <= APPLY_M;
          end
        end
        MEAS_M: begin
          if (pwr_take) begin
            pm    <= i_pwr;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          center   <= code_next;
          tune     <= code_next;
          tune_val <= 1'b1;
          state    <= APPLY_C;
          if (code_next != center) begin
            stable <= '0;
            locked <= 1'b0;
          end else if (stable != LOCK_MAX) begin
            stable <= stable_nx;
            if (stable_nx == LOCK_MAX) locked <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_peaks_rdy     = (state == WAIT_PEAKS);
  assign o_pwr_rdy       = meas;
  assign o_lock_err      = (state == ERR);
  assign o_ring_tune_val = tune_val;
  assign o_ring_tune     = tune;
  assign o_locked        = locked;
  assign o_mon_center    = center;
  assign o_mon_state     = state;

endmodule

// File: tb/tb_tuner_lock_phy.sv
// Directed bench for tuner_lock_phy; power comes from a simple peaked model of the tune code.
module tb_tuner_lock_phy;
  import tuner_phy_pkg::*;

`ifdef TUNER_LOCK_DISCARD_EN
  localparam int ITER = 10;
`else
  localparam int ITER = 7;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              lock_en;
  logic [1:0]        lock_sel;
  logic              peaks_val;
  logic              peaks_rdy;
  logic [31:0]       ring_tune_peaks;
  logic [31:0]       pwr_peaks;
  logic [2:0]        peaks_cnt;
  logic              tune_val;
  logic              tune_rdy;
  logic [7:0]        tune;
  logic              pwr_val;
  logic              pwr_rdy;
  logic [7:0]        pwr;
  logic              locked;
  logic              lock_err;
  logic [7:0]        mon_center;
  tuner_lock_state_e mon_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_c  = 0;
  int peak_code;
  logic       ovr;
  logic [7:0] ovr_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pwr_val && pwr_rdy && mon_state == MEAS_C) hs_c <= hs_c + 1;

  function automatic logic [7:0] model(input logic [7:0] code, input int pk);
    int d;
    int v;
    d = int'(code) - pk;
    if (d < 0) d = -d;
    v = 250 - 20 * d;
    if (v < 0) v = 0;
    return 8'(v);
  endfunction

  assign pwr = ovr ? ovr_val : model(tune, peak_code);

  tuner_lock_phy #(
    .DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(4), .DITHER_STEP(1), .LOCK_COUNT(4)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_lock_en         (lock_en),
    .i_lock_sel        (lock_sel),
    .i_peaks_val       (peaks_val),
    .o_peaks_rdy       (peaks_rdy),
    .i_ring_tune_peaks (ring_tune_peaks),
    .i_pwr_peaks       (pwr_peaks),
    .i_peaks_cnt       (peaks_cnt),
    .o_ring_tune_val   (tune_val),
    .i_ring_tune_rdy   (tune_rdy),
    .o_ring_tune       (tune),
    .i_pwr_val         (pwr_val),
    .o_pwr_rdy         (pwr_rdy),
    .i_pwr             (pwr),
    .o_locked          (locked),
    .o_lock_err        (lock_err),
    .o_mon_center      (mon_center),
    .o_mon_state       (mon_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input tuner_lock_state_e s, input int budget, input string tag);
    int n;
    n = 0;
    while (mon_state !== s && n < budget) begin tick(); n++; end
    total++;
    assert (mon_state === s) else begin
      bad++;
      $error("FAIL %s timeout state=%0d expected=%0d", tag, mon_state, s);
    end
  endtask

  task automatic abort();
    lock_en = 1'b0;
    tick();
  endtask

  initial begin
    int t0;
    int n;
    int hs0;
    int exp_c [4];
    rst = 1'b1; lock_en = 1'b0; lock_sel = '0; peaks_val = 1'b0;
    ring_tune_peaks = {8'd0, 8'd150, 8'd90, 8'd40};
    pwr_peaks = {8'd0, 8'd30, 8'd200, 8'd60};
    peaks_cnt = 3'd3; tune_rdy = 1'b1; pwr_val = 1'b1;
    ovr = 1'b0; ovr_val = '0; peak_code = 90;
    #12;
    check("rst_state", mon_state, IDLE);
    check("rst_outs", {peaks_rdy, tune_val, pwr_rdy, locked, lock_err}, 5'b0);
    check("rst_tune", tune, 0);
    check("rst_center", mon_center, 0);
    rst = 1'b0;

    // Normal lock at code 90
    lock_sel = 2'd1; peaks_val = 1'b1; lock_en = 1'b1;
    tick();
    check("wait_state", mon_state, WAIT_PEAKS);
    check("peaks_rdy", peaks_rdy, 1);
    tick();
    t0 = cyc;
    peaks_val = 1'b0;
    check("applyc_state", mon_state, APPLY_C);
    check("applyc_tune", {tune_val, tune}, {1'b1, 8'd90});
    check("applyc_center", mon_center, 90);
    check("applyc_peaks_rdy", peaks_rdy, 0);
    wait_state(APPLY_P, 30, "to_apply_p");
    check("applyp_tune", {tune_val, tune}, {1'b1, 8'd91});
    wait_state(APPLY_M, 30, "to_apply_m");
    check("applym_tune", {tune_val, tune}, {1'b1, 8'd89});
    n = 0;
    while (!locked && n < 200) begin tick(); n++; end
    check("lock_latency", cyc - t0, 4 * ITER);
    check("lock_center", {locked, mon_center}, {1'b1, 8'd90});
    tick();
    check("lock_held", locked, 1);
    abort();
    check("abort_state", mon_state, IDLE);
    check("abort_outs", {locked, tune_val, peaks_rdy}, 3'b0);

    // Climb from 40 to 43
    peak_code = 43; lock_sel = 2'd0; peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(APPLY_C, 10, "climb_start");
    peaks_val = 1'b0;
    check("climb_c0", mon_center, 40);
    exp_c = '{41, 42, 43, 43};
    for (int i = 0; i < 4; i++) begin
      wait_state(UPDATE, 30, "climb_upd");
      tick();
      check("climb_center", {locked, mon_center}, {1'b0, 8'(exp_c[i])});
    end
    n = 0;
    while (!locked && n < 200) begin tick(); n++; end
    check("climb_lock", {locked, mon_center}, {1'b1, 8'd43});
    abort();

    // Error: sel beyond count, then empty list
    peaks_cnt = 3'd2; lock_sel = 2'd3; peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(WAIT_PEAKS, 5, "err_wait");
    check("err_pre", lock_err, 0);
    tick();
    check("err_state", {mon_state, lock_err, tune_val}, {ERR, 1'b1, 1'b0});
    tick(); tick(); tick();
    check("err_hold", {mon_state, lock_err, tune_val, peaks_rdy}, {ERR, 1'b1, 1'b0, 1'b0});
    abort();
    check("err_clear", {mon_state, lock_err}, {IDLE, 1'b0});
    peaks_cnt = 3'd0; lock_sel = 2'd0; lock_en = 1'b1;
    wait_state(ERR, 5, "err_cnt0");
    check("err_cnt0_flag", lock_err, 1);
    abort();

    // Saturation at 255 and 0
    ring_tune_peaks = {8'd0, 8'd0, 8'd0, 8'd255};
    peaks_cnt = 3'd2; lock_sel = 2'd0; peak_code = 255; peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(APPLY_C, 10, "sat_hi");
    peaks_val = 1'b0;
    check("sat_hi_c", tune, 255);
    wait_state(APPLY_P, 30, "sat_hi_p");
    check("sat_hi_p_tune", tune, 255);
    wait_state(APPLY_M, 30, "sat_hi_m");
    check("sat_hi_m_tune", tune, 254);
    abort();
    lock_sel = 2'd1; peak_code = 0; peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(APPLY_C, 10, "sat_lo");
    peaks_val = 1'b0;
    check("sat_lo_c", tune, 0);
    wait_state(APPLY_P, 30, "sat_lo_p");
    check("sat_lo_p_tune", tune, 1);
    wait_state(APPLY_M, 30, "sat_lo_m");
    check("sat_lo_m_tune", tune, 0);
    abort();

    // Backpressure, then abort coinciding with the tune handshake
    ring_tune_peaks = {8'd0, 8'd150, 8'd90, 8'd40};
    peaks_cnt = 3'd3; lock_sel = 2'd2; peak_code = 150; tune_rdy = 1'b0;
    peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(APPLY_C, 10, "bp_start");
    peaks_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {mon_state, tune_val, pwr_rdy, tune}, {APPLY_C, 1'b1, 1'b0, 8'd150});
    end
    tune_rdy = 1'b1;
    abort();
    check("bp_abort", {mon_state, tune_val}, {IDLE, 1'b0});

    // MEAS_C sample sequence 10 then 200; plus/minus both 100
    ovr = 1'b1; ovr_val = 8'd10; pwr_val = 1'b0;
    lock_sel = 2'd1; peaks_val = 1'b1; lock_en = 1'b1;
    wait_state(MEAS_C, 10, "disc_meas");
    peaks_val = 1'b0;
    hs0 = hs_c;
    pwr_val = 1'b1;
    tick();
`ifdef TUNER_LOCK_DISCARD_EN
    check("disc_first", mon_state, MEAS_C);
    ovr_val = 8'd200;
    tick();
    check("disc_second", mon_state, APPLY_P);
    check("disc_hs", hs_c - hs0, 2);
    ovr_val = 8'd100;
    wait_state(UPDATE, 30, "disc_upd");
    tick();
    check("disc_center", mon_center, 90);
`else
    check("meas_first", mon_state, APPLY_P);
    check("meas_hs", hs_c - hs0, 1);
    ovr_val = 8'd100;
    wait_state(UPDATE, 30, "meas_upd");
    tick();
    check("tie_plus_center", mon_center, 91);
`endif

    // Asynchronous reset mid-operation
    wait_state(MEAS_C, 20, "arst_meas");
    #2 rst = 1'b1;
    #1;
    check("arst_state", {mon_state, tune_val, pwr_rdy, locked}, {IDLE, 3'b0});
    check("arst_regs", {tune, mon_center}, 16'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
